// File: rtl/axi_rd_split.sv
// AXI read-path burst splitter: re-issues over-long or 4 KiB-crossing AR bursts as
// legal chunks and masks the intermediate rlast flags so upstream sees one burst.
module axi_rd_split #(
  parameter int MAX_LEN = 63,
  parameter int MAX_OUT = 64,
  parameter int ID_W    = 16,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  // upstream AR / R
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready,
  // upstream AW / W / B
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  // downstream AR / R
  output logic [ID_W-1:0]     m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [ID_W-1:0]     m_rid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  // downstream AW / W / B
  output logic [ID_W-1:0]     m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [ID_W-1:0]     m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  localparam int OUT_W = $clog2(MAX_OUT) + 1;
  localparam logic [8:0]     MAX_BEATS = 9'(MAX_LEN + 1);
  localparam logic [OUT_W:0] OCC_MAX   = (OUT_W+1)'(MAX_OUT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [1:0]        state;
  logic              ao_valid;
  logic [ID_W-1:0]   ao_id;
  logic [ADDR_W-1:0] ao_addr;
  logic [7:0]        ao_len;
  logic [2:0]        ao_size;
  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W:0]    occ;
  logic [ID_W-1:0]   p_id;
  logic [ADDR_W-1:0] p_addr;
  logic [2:0]        p_size;
  logic [8:0]        rem, nchunk, rdone, chunk;
  logic              ao_loadable, s_hs, split, m_ar_hs, m_rl_hs, issue_ld, pass_ld;
  logic              in_split, final_beat;

  function automatic logic need_split_f(input logic [11:0] addr_lo, input logic [7:0] len,
                                        input logic [2:0] size);
    logic [13:0] span;
    logic [13:0] sum;
    span = (14'(len) + 14'd1) << size;
    sum  = {2'b00, addr_lo} + span;
    return (9'(len) > 9'(MAX_LEN)) || (sum > 14'd4096);
  endfunction

  // Largest legal chunk: bounded by remaining beats, MAX_LEN+1 and room to the 4 KiB page end.
  function automatic logic [8:0] chunk_beats(input logic [8:0] left, input logic [11:0] addr_lo,
                                             input logic [2:0] size);
    logic [12:0] room;
    logic [12:0] c;
    room = (13'd4096 - {1'b0, addr_lo}) >> size;
    c    = {4'd0, left};
    if (c > {4'd0, MAX_BEATS}) c = {4'd0, MAX_BEATS};
    if (c > room) c = room;
    return c[8:0];
  endfunction

  assign ao_loadable = !ao_valid || m_arready;
  assign occ         = {1'b0, outstanding} + {{OUT_W{1'b0}}, ao_valid};
  assign s_arready   = rst_n && (state == IDLE) && ao_loadable && (occ < OCC_MAX);
  assign s_hs        = s_arvalid && s_arready;
  assign split       = need_split_f(s_araddr[11:0], s_arlen, s_arsize);
  assign pass_ld     = s_hs && !split;
  assign m_ar_hs     = ao_valid && m_arready;
  assign m_rl_hs     = m_rvalid && m_rready && m_rlast;
  assign chunk       = chunk_beats(rem, p_addr[11:0], p_size);
  assign issue_ld    = (state == ISSUE) && ao_loadable;

  // Only the final beat of the final chunk of a split parent keeps its rlast.
  assign in_split   = (state == ISSUE) || (state == WAIT);
  assign final_beat = (rem == 9'd0) && (rdone + 9'd1 == nchunk);

  assign m_arid    = ao_id;
  assign m_araddr  = ao_addr;
  assign m_arlen   = ao_len;
  assign m_arsize  = ao_size;
  assign m_arvalid = ao_valid;

  assign m_rready = s_rready;
  assign s_rvalid = m_rvalid;
  assign s_rid    = m_rid;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast && !(in_split && !final_beat);

  assign m_awid    = s_awid;
  assign m_awaddr  = s_awaddr;
  assign m_awlen   = s_awlen;
  assign m_awsize  = s_awsize;
  assign m_awvalid = s_awvalid;
  assign s_awready = m_awready;
  assign m_wdata   = s_wdata;
  assign m_wstrb   = s_wstrb;
  assign m_wlast   = s_wlast;
  assign m_wvalid  = s_wvalid;
  assign s_wready  = m_wready;
  assign s_bid     = m_bid;
  assign s_bresp   = m_bresp;
  assign s_bvalid  = m_bvalid;
  assign m_bready  = s_bready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ao_valid    <= 1'b0;
      outstanding <= '0;
      rem         <= '0;
      nchunk      <= '0;
      rdone       <= '0;
    end else begin
      if (m_ar_hs && !m_rl_hs)      outstanding <= outstanding + 1'b1;
      else if (!m_ar_hs && m_rl_hs) outstanding <= outstanding - 1'b1;

      if (pass_ld || issue_ld) ao_valid <= 1'b1;
      else if (m_arready)      ao_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (s_hs && split) begin
            rem    <= 9'(s_arlen) + 9'd1;
            nchunk <= '0;
            rdone  <= '0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (outstanding == '0 && !ao_valid) state <= ISSUE;
        end
        ISSUE: begin
          if (issue_ld) begin
            rem    <= rem - chunk;
            nchunk <= nchunk + 9'd1;
            if (rem == chunk) state <= WAIT;
          end
          if (m_rl_hs) rdone <= rdone + 9'd1;
        end
        default: begin
          if (m_rl_hs) begin
            rdone <= rdone + 9'd1;
            if (rdone + 9'd1 == nchunk) state <= IDLE;
          end
        end
      endcase
    end
  end

  // AR payload registers carry no reset; ao_valid qualifies them.
  always_ff @(posedge clk) begin
    if (pass_ld) begin
      ao_id   <= s_arid;
      ao_addr <= s_araddr;
      ao_len  <= s_arlen;
      ao_size <= s_arsize;
    end else if (issue_ld) begin
      ao_id   <= p_id;
      ao_addr <= p_addr;
      ao_len  <= 8'(chunk - 9'd1);
      ao_size <= p_size;
    end
    if (s_hs && split) begin
      p_id   <= s_arid;
      p_addr <= s_araddr;
      p_size <= s_arsize;
    end else if (issue_ld) begin
      p_addr <= p_addr + (ADDR_W'(chunk) << p_size);
    end
  end

endmodule
